// File: rtl/sys_pkg.sv
// Shared encodings for the SYSTEM-instruction executor: opcodes, CSR-file
// command codes, supported CSR addresses and FSM/op-class enums.
package sys_pkg;

    localparam logic [6:0]  OPC_SYSTEM = 7'b1110011;
    localparam logic [2:0]  F3_CSRRW   = 3'b001;
    localparam logic [2:0]  F3_CSRRS   = 3'b010;
    localparam logic [31:0] ECALL_W    = 32'h0000_0073;
    localparam logic [31:0] MRET_W     = 32'h3020_0073;

    localparam logic [2:0] CTR_NONE  = 3'b000;
    localparam logic [2:0] CTR_ECALL = 3'b010;
    localparam logic [2:0] CTR_MRET  = 3'b011;
    localparam logic [2:0] CTR_CSRRW = 3'b100;
    localparam logic [2:0] CTR_CSRRS = 3'b110;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    typedef enum logic [2:0] {S_IDLE, S_READ, S_WRITE, S_TRAP, S_DONE} state_e;
    typedef enum logic [2:0] {OP_NONE, OP_CSRRW, OP_CSRRS, OP_ECALL, OP_MRET} op_e;

    function automatic logic csr_known(input logic [11:0] addr);
        return (addr == CSR_MSTATUS) || (addr == CSR_MTVEC) ||
               (addr == CSR_MEPC)    || (addr == CSR_MCAUSE);
    endfunction

endpackage

// File: rtl/sys_decode.sv
// Pure combinational classification of a SYSTEM instruction word.
module sys_decode
    import sys_pkg::*;
(
    input  logic [31:0] inst,
    output op_e         op,
    output logic        illegal,
    output logic        rs1_zero
);

    // CSR ops touching a CSR outside the implemented set fall through as illegal.
    always_comb begin
        op = OP_NONE;
        if (inst == ECALL_W)
            op = OP_ECALL;
        else if (inst == MRET_W)
            op = OP_MRET;
        else if (inst[6:0] == OPC_SYSTEM && csr_known(inst[31:20])) begin
            if (inst[14:12] == F3_CSRRW)
                op = OP_CSRRW;
            else if (inst[14:12] == F3_CSRRS)
                op = OP_CSRRS;
        end
    end

    assign illegal  = (op == OP_NONE);
    assign rs1_zero = (inst[19:15] == 5'd0);

endmodule

// File: rtl/sys_exec.sv
// Multi-cycle SYSTEM instruction executor: CSR read/modify/write, ecall/mret
// trap redirection, illegal-encoding reporting. All outputs are registered.
module sys_exec
    import sys_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] inst,
    input  logic [31:0] pc,
    input  logic [31:0] rs1_data,
    output logic [2:0]  csr_ctr,
    output logic [11:0] csr_addr,
    output logic [31:0] csr_wd,
    input  logic [31:0] csr_rd,
    input  logic [31:0] csr_pc,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        illegal
);

    state_e      state;
    op_e         op_q;
    logic        rs1_zero_q;
    logic [4:0]  rd_q;
    logic [31:0] pc_q;
    logic [31:0] rs1_q;
    logic [31:0] old_q;
    logic [31:0] redirect_pc_q;
    logic        illegal_q;

    op_e  dec_op;
    logic dec_illegal;
    logic dec_rs1_zero;

    sys_decode u_decode (
        .inst     (inst),
        .op       (dec_op),
        .illegal  (dec_illegal),
        .rs1_zero (dec_rs1_zero)
    );

    assign rf_wdata    = old_q;
    assign redirect_pc = redirect_pc_q;
    assign illegal     = illegal_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            in_ready      <= 1'b1;
            op_q          <= OP_NONE;
            rs1_zero_q    <= 1'b0;
            rd_q          <= '0;
            pc_q          <= '0;
            rs1_q         <= '0;
            old_q         <= '0;
            redirect_pc_q <= '0;
            illegal_q     <= 1'b0;
            csr_ctr       <= CTR_NONE;
            csr_addr      <= '0;
            csr_wd        <= '0;
            rf_we         <= 1'b0;
            rf_waddr      <= '0;
            out_valid     <= 1'b0;
            redirect      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (in_valid) begin
                    in_ready   <= 1'b0;
                    op_q       <= dec_op;
                    rs1_zero_q <= dec_rs1_zero;
                    rd_q       <= inst[11:7];
                    pc_q       <= pc;
                    rs1_q      <= rs1_data;
                    if (dec_illegal) begin
                        state         <= S_DONE;
                        illegal_q     <= 1'b1;
                        out_valid     <= 1'b1;
                        redirect      <= 1'b0;
                        redirect_pc_q <= pc + 32'd4;
                    end else if (dec_op == OP_ECALL || dec_op == OP_MRET) begin
                        state    <= S_TRAP;
                        csr_ctr  <= (dec_op == OP_ECALL) ? CTR_ECALL : CTR_MRET;
                        csr_addr <= '0;
                        csr_wd   <= '0;
                    end else begin
                        state    <= S_READ;
                        csr_addr <= inst[31:20];
                    end
                end
                S_READ: begin
                    // csrrs with rs1=x0 is a pure read: no CSR write command.
                    state    <= S_WRITE;
                    old_q    <= csr_rd;
                    csr_wd   <= rs1_q;
                    csr_ctr  <= (op_q == OP_CSRRW) ? CTR_CSRRW :
                                (rs1_zero_q ? CTR_NONE : CTR_CSRRS);
                    rf_we    <= (rd_q != 5'd0);
                    rf_waddr <= rd_q;
                end
                S_WRITE: begin
                    state         <= S_DONE;
                    csr_ctr       <= CTR_NONE;
                    rf_we         <= 1'b0;
                    out_valid     <= 1'b1;
                    redirect      <= 1'b0;
                    redirect_pc_q <= pc_q + 32'd4;
                end
                S_TRAP: begin
                    state         <= S_DONE;
                    csr_ctr       <= CTR_NONE;
                    out_valid     <= 1'b1;
                    redirect      <= 1'b1;
                    redirect_pc_q <= csr_pc;
                end
                S_DONE: if (out_ready) begin
                    state     <= S_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    redirect  <= 1'b0;
                    illegal_q <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/sys_exec.md
SYS_EXEC -- requirements
Module: sys_exec

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk input 1, rising-edge clock; rst_n input 1, asynchronous active-low reset.
REQ-002 Handshake in, in order: in_valid input 1 (instruction offered); in_ready output 1 (block idle, can accept); inst input 32 (SYSTEM instruction word); pc input 32 (instruction address); rs1_data input 32 (register-file value of inst[19:15]).
REQ-003 CSR-file side: csr_ctr output 3 (000 none, 010 ecall, 011 mret, 100 csrrw, 110 csrrs); csr_addr output 12 (CSR index); csr_wd output 32 (write operand); csr_rd input 32 (combinational CSR read data); csr_pc input 32 (trap target: mtvec when csr_ctr[0]=0, mepc when csr_ctr[0]=1).
REQ-004 Register-file side: rf_we output 1; rf_waddr output 5; rf_wdata output 32.
REQ-005 Completion: out_valid output 1; out_ready input 1; redirect output 1 (next PC is redirect_pc, not pc+4); redirect_pc output 32; illegal output 1 (unsupported SYSTEM encoding).
REQ-006 Parameter: none; the supported CSR set is mstatus 0x300, mtvec 0x305, mepc 0x341, mcause 0x342.

Function
REQ-007 FSM states SHALL be IDLE, READ, WRITE, TRAP, DONE; in_ready=1 only in IDLE.
REQ-008 IDLE: on in_valid&in_ready, latch inst, pc and rs1_data; decode; csrrw/csrrs -> READ; ecall (0x00000073) or mret (0x30200073) -> TRAP; any other word -> DONE with illegal_q=1.
REQ-009 READ (1 cycle): csr_addr=inst_q[31:20], csr_ctr=000; capture csr_rd into old_q; -> WRITE.
REQ-010 WRITE (1 cycle): csr_addr held; csr_ctr=100 for csrrw, 110 for csrrs; csr_wd=rs1_q; rf_we=1 when inst_q[11:7]!=0, rf_waddr=inst_q[11:7], rf_wdata=old_q; -> DONE.
REQ-011 csrrs with rs1 index 0 SHALL keep csr_ctr=000 in WRITE (read-only, no CSR side effect); csrrw SHALL always write, even when rd=x0.
REQ-012 TRAP (1 cycle): csr_ctr=010 (ecall) or 011 (mret); csr_addr=0, csr_wd=0; capture csr_pc into redirect_pc_q; -> DONE.
REQ-013 DONE: out_valid=1; redirect=1 and redirect_pc=redirect_pc_q for ecall/mret, else redirect=0 and redirect_pc=pc_q+4 (32-bit wrap); illegal=illegal_q; hold all outputs until out_ready=1, then -> IDLE and clear illegal_q.
REQ-014 Outside WRITE and TRAP, csr_ctr SHALL be 000 and rf_we SHALL be 0, so no CSR or register write can repeat while DONE stalls.
REQ-015 Supported CSR encodings: opcode 1110011 with funct3 001 (csrrw) or 010 (csrrs); funct3 011, 101, 110, 111 and all other SYSTEM words SHALL be illegal, with no CSR or register write.
REQ-016 Latency: csr ops 3 cycles accept-to-out_valid; ecall/mret 2 cycles; illegal 1 cycle; throughput is 1 instruction per (latency+1) cycles with out_ready held high.
REQ-017 in_valid while not IDLE SHALL be ignored; inputs are sampled only at the accept edge.

Reset
REQ-018 rst_n low SHALL force IDLE asynchronously: in_ready=1; out_valid, redirect, illegal, rf_we=0; csr_ctr=000; csr_addr, csr_wd, rf_waddr, rf_wdata, redirect_pc=0; all latches=0.
REQ-019 Reset during READ, WRITE, TRAP or DONE SHALL abandon the instruction; after release, no partial CSR or register write is replayed.

Structure
REQ-020 Shared package sys_pkg SHALL hold opcode SYSTEM, funct3 codes, the ECALL/MRET words, the csr_ctr encodings, CSR addresses and the state enum.
REQ-021 Combinational decode (op class, illegal flag, rs1-zero flag) SHALL be a sub-module sys_decode; the FSM and datapath latches stay in sys_exec.

Verification
REQ-022 csrrw x5, mtvec, x6 with rs1_data=0x80000100 and csr_rd=0x0 -> WRITE cycle: csr_ctr=100, csr_addr=0x305, csr_wd=0x80000100, rf_we=1, rf_waddr=5, rf_wdata=0; DONE: redirect=0, redirect_pc=pc+4.
REQ-023 csrrs x0, mstatus, x0 with csr_rd=0x1800 -> csr_ctr stays 000 every cycle, rf_we=0, out_valid after 3 cycles.
REQ-024 ecall at pc=0x80000010 with csr_pc=0x80000400 -> TRAP: csr_ctr=010; DONE: redirect=1, redirect_pc=0x80000400; then mret with csr_pc=0x80000014 -> csr_ctr=011, redirect_pc=0x80000014.
REQ-025 csrrc word (funct3 011) -> out_valid next cycle with illegal=1, no rf_we, csr_ctr=000 throughout.
REQ-026 out_ready held low 5 cycles in DONE -> outputs stable, in_ready=0, single WRITE pulse only; rst_n asserted during WRITE -> all outputs zero immediately, in_ready=1.
REQ-027 pc=0xFFFFFFFC csrrs op -> redirect_pc=0x00000000.
